ras_ckpt: RTL and testbench

RAS_CKPT -- requirements
Module: ras_ckpt

---
 rtl/ras_ckpt.sv | 197 +++++++++++++++++++
 tb/tb_ras_ckpt.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ras_ckpt.sv
// ras_ckpt: return address stack with per-entry recursion counters and
// single-word checkpoint/restore for branch misprediction recovery.
//
// Ports
//   clk                    : clock, all state updates on the rising edge
//   rst                    : asynchronous active-low reset
//   bp_ras_push            : call seen, push bp_ras_addr
//   bp_ras_pop             : return seen, pop top of stack
//   bp_ras_addr            : return address to push
//   bp_ras_restore         : load bp_ras_restore_ckpt (overrides push/pop)
//   bp_ras_restore_ckpt    : snapshot previously taken from ras_bp_ckpt
//   ras_bp_addr            : predicted return address (0 when empty)
//   ras_bp_valid           : stack non-empty
//   ras_bp_ckpt            : {ptr, num, buf[ptr], cnt[ptr]} of current state
//   ras_csrf_ras_full_add  : one-cycle pulse, oldest entry overwritten
//   ras_csrf_ras_empty_add : one-cycle pulse, pop on empty stack
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module ras_ckpt #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
    parameter int unsigned CNT_WIDTH  = 4,
    localparam int unsigned PTR_W     = $clog2(DEPTH),
    localparam int unsigned CKPT_W    = 2*PTR_W + 1 + ADDR_WIDTH + CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bp_ras_push,
    input  logic                  bp_ras_pop,
    input  logic [ADDR_WIDTH-1:0] bp_ras_addr,
    input  logic                  bp_ras_restore,
    input  logic [CKPT_W-1:0]     bp_ras_restore_ckpt,
    output logic [ADDR_WIDTH-1:0] ras_bp_addr,
    output logic                  ras_bp_valid,
    output logic [CKPT_W-1:0]     ras_bp_ckpt,
    output logic                  ras_csrf_ras_full_add,
    output logic                  ras_csrf_ras_empty_add
);

    localparam int unsigned NUM_W = PTR_W + 1;
    localparam logic [NUM_W-1:0]     NUM_FULL = NUM_W'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    // Storage and bookkeeping registers
    logic [ADDR_WIDTH-1:0] r_buf [DEPTH];
    logic [CNT_WIDTH-1:0]  r_cnt [DEPTH];
    logic [PTR_W-1:0]      r_ptr;
    logic [NUM_W-1:0]      r_num;
    logic                  r_full_add;
    logic                  r_empty_add;

    // Derived views of current state
    logic [PTR_W-1:0]      w_ptr_inc;
    logic [PTR_W-1:0]      w_ptr_dec;
    logic [NUM_W-1:0]      w_num_inc;
    logic [ADDR_WIDTH-1:0] w_top_addr;
    logic [CNT_WIDTH-1:0]  w_top_cnt;
    logic                  w_empty;
    logic                  w_hit;

    // Checkpoint fields being restored
    logic [PTR_W-1:0]      w_ck_ptr;
    logic [NUM_W-1:0]      w_ck_num;
    logic [ADDR_WIDTH-1:0] w_ck_addr;
    logic [CNT_WIDTH-1:0]  w_ck_cnt;

    // Next-state controls: port "ent" writes a whole entry, port "cnt" only a counter
    logic [PTR_W-1:0]      w_ptr_nxt;
    logic [NUM_W-1:0]      w_num_nxt;
    logic                  w_ent_we;
    logic [PTR_W-1:0]      w_ent_idx;
    logic [ADDR_WIDTH-1:0] w_ent_addr;
    logic [CNT_WIDTH-1:0]  w_ent_cnt;
    logic                  w_cnt_we;
    logic [PTR_W-1:0]      w_cnt_idx;
    logic [CNT_WIDTH-1:0]  w_cnt_val;
    logic                  w_push_new;
    logic                  w_full_nxt;
    logic                  w_empty_nxt;

    assign w_ptr_inc  = r_ptr + PTR_W'(1);
    assign w_ptr_dec  = r_ptr - PTR_W'(1);
    assign w_num_inc  = (r_num == NUM_FULL) ? NUM_FULL : r_num + NUM_W'(1);
    assign w_top_addr = r_buf[r_ptr];
    assign w_top_cnt  = r_cnt[r_ptr];
    assign w_empty    = (r_num == '0);
    assign w_hit      = (bp_ras_addr == w_top_addr);

    assign w_ck_ptr  = bp_ras_restore_ckpt[CKPT_W-1 -: PTR_W];
    assign w_ck_num  = bp_ras_restore_ckpt[CKPT_W-PTR_W-1 -: NUM_W];
    assign w_ck_addr = bp_ras_restore_ckpt[CNT_WIDTH +: ADDR_WIDTH];
    assign w_ck_cnt  = bp_ras_restore_ckpt[CNT_WIDTH-1:0];

    // Prediction and snapshot outputs come straight from pre-edge state
    assign ras_bp_valid           = ~w_empty;
    assign ras_bp_addr            = w_empty ? '0 : w_top_addr;
    assign ras_bp_ckpt            = {r_ptr, r_num, w_top_addr, w_top_cnt};
    assign ras_csrf_ras_full_add  = r_full_add;
    assign ras_csrf_ras_empty_add = r_empty_add;

    // Next-state decode: restore > push+pop > push > pop
    always_comb begin
        w_ptr_nxt   = r_ptr;
        w_num_nxt   = r_num;
        w_ent_we    = 1'b0;
        w_ent_idx   = r_ptr;
        w_ent_addr  = bp_ras_addr;
        w_ent_cnt   = CNT_ONE;
        w_cnt_we    = 1'b0;
        w_cnt_idx   = r_ptr;
        w_cnt_val   = w_top_cnt;
        w_push_new  = 1'b0;
        w_full_nxt  = 1'b0;
        w_empty_nxt = 1'b0;

        if (bp_ras_restore) begin
            w_ptr_nxt  = w_ck_ptr;
            w_num_nxt  = w_ck_num;
            w_ent_we   = 1'b1;
            w_ent_idx  = w_ck_ptr;
            w_ent_addr = w_ck_addr;
            w_ent_cnt  = w_ck_cnt;
        end else if (bp_ras_push && bp_ras_pop) begin
            if (w_empty) begin
                w_push_new = 1'b1;
            end else if (!w_hit) begin
                if (w_top_cnt > CNT_ONE) begin
                    // Release one recursion level, then push the new target
                    w_cnt_we   = 1'b1;
                    w_cnt_val  = w_top_cnt - CNT_ONE;
                    w_push_new = 1'b1;
                end else begin
                    // Single-use top: replace it in place
                    w_ent_we = 1'b1;
                end
            end
        end else if (bp_ras_push) begin
            if (!w_empty && w_hit && (w_top_cnt != CNT_MAX)) begin
                w_cnt_we  = 1'b1;
                w_cnt_val = w_top_cnt + CNT_ONE;
            end else begin
                w_push_new = 1'b1;
            end
        end else if (bp_ras_pop) begin
            if (w_empty) begin
                w_empty_nxt = 1'b1;
            end else if (w_top_cnt > CNT_ONE) begin
                w_cnt_we  = 1'b1;
                w_cnt_val = w_top_cnt - CNT_ONE;
            end else begin
                w_ptr_nxt = w_ptr_dec;
                w_num_nxt = r_num - NUM_W'(1);
            end
        end

        // New entry above top; at full occupancy this overwrites the oldest
        if (w_push_new) begin
            w_ptr_nxt  = w_ptr_inc;
            w_num_nxt  = w_num_inc;
            w_ent_we   = 1'b1;
            w_ent_idx  = w_ptr_inc;
            w_ent_addr = bp_ras_addr;
            w_ent_cnt  = CNT_ONE;
            w_full_nxt = (r_num == NUM_FULL);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr       <= PTR_W'(DEPTH - 1);
            r_num       <= '0;
            r_full_add  <= 1'b0;
            r_empty_add <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_num       <= w_num_nxt;
            r_full_add  <= w_full_nxt;
            r_empty_add <= w_empty_nxt;
            if (w_cnt_we) begin
                r_cnt[w_cnt_idx] <= w_cnt_val;
            end
            if (w_ent_we) begin
                r_buf[w_ent_idx] <= w_ent_addr;
                r_cnt[w_ent_idx] <= w_ent_cnt;
            end
        end
    end

endmodule

// File: tb/tb_ras_ckpt.sv
// Scoreboard bench for ras_ckpt with DEPTH=4, CNT_WIDTH=2, ADDR_WIDTH=16.
module tb_ras_ckpt;

    localparam int unsigned AW = 16;
    localparam int unsigned CW = 23;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
        logic [1:0]    ptr;
        logic [2:0]    num;
        logic [1:0]    cnt;
        logic          full;
        logic          empty;
    } obs_t;

    logic          clk;
    logic          rst;
    logic          bp_ras_push;
    logic          bp_ras_pop;
    logic [AW-1:0] bp_ras_addr;
    logic          bp_ras_restore;
    logic [CW-1:0] bp_ras_restore_ckpt;
    logic [AW-1:0] ras_bp_addr;
    logic          ras_bp_valid;
    logic [CW-1:0] ras_bp_ckpt;
    logic          ras_csrf_ras_full_add;
    logic          ras_csrf_ras_empty_add;

    obs_t exp_q[$];
    obs_t obs_q[$];
    int   n_cmp;
    int   n_err;

    ras_ckpt #(.DEPTH(4), .ADDR_WIDTH(AW), .CNT_WIDTH(2)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .bp_ras_push            (bp_ras_push),
        .bp_ras_pop             (bp_ras_pop),
        .bp_ras_addr            (bp_ras_addr),
        .bp_ras_restore         (bp_ras_restore),
        .bp_ras_restore_ckpt    (bp_ras_restore_ckpt),
        .ras_bp_addr            (ras_bp_addr),
        .ras_bp_valid           (ras_bp_valid),
        .ras_bp_ckpt            (ras_bp_ckpt),
        .ras_csrf_ras_full_add  (ras_csrf_ras_full_add),
        .ras_csrf_ras_empty_add (ras_csrf_ras_empty_add)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic obs_t ev(input logic v, input logic [AW-1:0] a, input logic [1:0] p,
                                input logic [2:0] n, input logic [1:0] c,
                                input logic f, input logic e);
        obs_t s;
        s = '{valid: v, addr: a, ptr: p, num: n, cnt: c, full: f, empty: e};
        return s;
    endfunction

    function automatic obs_t sample();
        obs_t s;
        s = '{valid: ras_bp_valid, addr: ras_bp_addr, ptr: ras_bp_ckpt[22:21],
              num: ras_bp_ckpt[20:18], cnt: ras_bp_ckpt[1:0],
              full: ras_csrf_ras_full_add, empty: ras_csrf_ras_empty_add};
        return s;
    endfunction

    function automatic string fmt(input obs_t s);
        return $sformatf("v=%0b a=%h p=%0d n=%0d c=%0d full=%0b empty=%0b",
                         s.valid, s.addr, s.ptr, s.num, s.cnt, s.full, s.empty);
    endfunction

    // Drive one cycle of stimulus, log expectation, capture the post-edge outputs
    task automatic drive(input logic push, input logic pop, input logic rs,
                         input logic [AW-1:0] a, input logic [CW-1:0] ck, input obs_t e);
        bp_ras_push         = push;
        bp_ras_pop          = pop;
        bp_ras_restore      = rs;
        bp_ras_addr         = a;
        bp_ras_restore_ckpt = ck;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        obs_q.push_back(sample());
        bp_ras_push    = 1'b0;
        bp_ras_pop     = 1'b0;
        bp_ras_restore = 1'b0;
    endtask

    task automatic apply_reset();
        bp_ras_push         = 1'b0;
        bp_ras_pop          = 1'b0;
        bp_ras_restore      = 1'b0;
        bp_ras_addr         = '0;
        bp_ras_restore_ckpt = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        obs_t e, o;
        apply_reset();
        drive(0, 0, 0, '0, '0, ev(0, 16'h0, 2'd3, 3'd0, 2'd0, 0, 0));
        n_cmp++;
        if (ras_bp_ckpt !== {2'd3, 3'd0, 16'h0000, 2'd0}) begin
            n_err++;
            $display("FAIL reset_ckpt: got %h want %h", ras_bp_ckpt, {2'd3, 3'd0, 16'h0000, 2'd0});
        end
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL reset step %0d: got %s want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_recursion();
        obs_t e, o;
        apply_reset();
        drive(1, 0, 0, 16'h100, '0, ev(1, 16'h100, 2'd0, 3'd1, 2'd1, 0, 0));
        drive(1, 0, 0, 16'h100, '0, ev(1, 16'h100, 2'd0, 3'd1, 2'd2, 0, 0));
        drive(1, 0, 0, 16'h100, '0, ev(1, 16'h100, 2'd0, 3'd1, 2'd3, 0, 0));
        drive(1, 0, 0, 16'h100, '0, ev(1, 16'h100, 2'd1, 3'd2, 2'd1, 0, 0));
        drive(0, 1, 0, '0, '0, ev(1, 16'h100, 2'd0, 3'd1, 2'd3, 0, 0));
        drive(0, 1, 0, '0, '0, ev(1, 16'h100, 2'd0, 3'd1, 2'd2, 0, 0));
        drive(0, 1, 0, '0, '0, ev(1, 16'h100, 2'd0, 3'd1, 2'd1, 0, 0));
        drive(0, 1, 0, '0, '0, ev(0, 16'h0, 2'd3, 3'd0, 2'd0, 0, 0));
        drive(0, 1, 0, '0, '0, ev(0, 16'h0, 2'd3, 3'd0, 2'd0, 0, 1));
        drive(0, 0, 0, '0, '0, ev(0, 16'h0, 2'd3, 3'd0, 2'd0, 0, 0));
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL recursion step %0d: got %s want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_overflow();
        obs_t e, o;
        apply_reset();
        drive(1, 0, 0, 16'h10, '0, ev(1, 16'h10, 2'd0, 3'd1, 2'd1, 0, 0));
        drive(1, 0, 0, 16'h20, '0, ev(1, 16'h20, 2'd1, 3'd2, 2'd1, 0, 0));
        drive(1, 0, 0, 16'h30, '0, ev(1, 16'h30, 2'd2, 3'd3, 2'd1, 0, 0));
        drive(1, 0, 0, 16'h40, '0, ev(1, 16'h40, 2'd3, 3'd4, 2'd1, 0, 0));
        drive(1, 0, 0, 16'h50, '0, ev(1, 16'h50, 2'd0, 3'd4, 2'd1, 1, 0));
        drive(0, 0, 0, '0, '0, ev(1, 16'h50, 2'd0, 3'd4, 2'd1, 0, 0));
        drive(0, 1, 0, '0, '0, ev(1, 16'h40, 2'd3, 3'd3, 2'd1, 0, 0));
        drive(0, 1, 0, '0, '0, ev(1, 16'h30, 2'd2, 3'd2, 2'd1, 0, 0));
        drive(0, 1, 0, '0, '0, ev(1, 16'h20, 2'd1, 3'd1, 2'd1, 0, 0));
        drive(0, 1, 0, '0, '0, ev(0, 16'h0, 2'd0, 3'd0, 2'd1, 0, 0));
        drive(0, 1, 0, '0, '0, ev(0, 16'h0, 2'd0, 3'd0, 2'd1, 0, 1));
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL overflow step %0d: got %s want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_restore();
        obs_t e, o;
        logic [CW-1:0] ck_saved;
        logic [CW-1:0] ck_want;
        apply_reset();
        drive(1, 0, 0, 16'h10, '0, ev(1, 16'h10, 2'd0, 3'd1, 2'd1, 0, 0));
        drive(1, 0, 0, 16'h20, '0, ev(1, 16'h20, 2'd1, 3'd2, 2'd1, 0, 0));
        ck_saved = ras_bp_ckpt;
        ck_want  = {2'd1, 3'd2, 16'h0020, 2'd1};
        n_cmp++;
        if (ck_saved !== ck_want) begin
            n_err++;
            $display("FAIL restore_capture: got %h want %h", ck_saved, ck_want);
        end
        drive(1, 0, 0, 16'h30, '0, ev(1, 16'h30, 2'd2, 3'd3, 2'd1, 0, 0));
        drive(0, 1, 0, '0, '0, ev(1, 16'h20, 2'd1, 3'd2, 2'd1, 0, 0));
        drive(0, 1, 0, '0, '0, ev(1, 16'h10, 2'd0, 3'd1, 2'd1, 0, 0));
        drive(1, 0, 0, 16'h99, '0, ev(1, 16'h99, 2'd1, 3'd2, 2'd1, 0, 0));
        // Push asserted alongside restore must be ignored
        drive(1, 0, 1, 16'h55, ck_saved, ev(1, 16'h20, 2'd1, 3'd2, 2'd1, 0, 0));
        drive(0, 1, 0, '0, '0, ev(1, 16'h10, 2'd0, 3'd1, 2'd1, 0, 0));
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL restore step %0d: got %s want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_push_pop();
        obs_t e, o;
        apply_reset();
        drive(1, 1, 0, 16'h70, '0, ev(1, 16'h70, 2'd0, 3'd1, 2'd1, 0, 0));
        drive(1, 1, 0, 16'h70, '0, ev(1, 16'h70, 2'd0, 3'd1, 2'd1, 0, 0));
        drive(1, 1, 0, 16'h80, '0, ev(1, 16'h80, 2'd0, 3'd1, 2'd1, 0, 0));
        drive(1, 0, 0, 16'h80, '0, ev(1, 16'h80, 2'd0, 3'd1, 2'd2, 0, 0));
        drive(1, 1, 0, 16'h90, '0, ev(1, 16'h90, 2'd1, 3'd2, 2'd1, 0, 0));
        drive(0, 1, 0, '0, '0, ev(1, 16'h80, 2'd0, 3'd1, 2'd1, 0, 0));
        drive(0, 1, 0, '0, '0, ev(0, 16'h0, 2'd3, 3'd0, 2'd0, 0, 0));
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL push_pop step %0d: got %s want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t e, o;
        apply_reset();
        drive(1, 0, 0, 16'h11, '0, ev(1, 16'h11, 2'd0, 3'd1, 2'd1, 0, 0));
        drive(1, 0, 0, 16'h22, '0, ev(1, 16'h22, 2'd1, 3'd2, 2'd1, 0, 0));
        drive(1, 0, 0, 16'h33, '0, ev(1, 16'h33, 2'd2, 3'd3, 2'd1, 0, 0));
        // Assert reset between edges with a push pending
        bp_ras_push = 1'b1;
        bp_ras_addr = 16'h44;
        #3;
        rst = 1'b0;
        #1;
        exp_q.push_back(ev(0, 16'h0, 2'd3, 3'd0, 2'd0, 0, 0));
        obs_q.push_back(sample());
        @(posedge clk);
        #1;
        exp_q.push_back(ev(0, 16'h0, 2'd3, 3'd0, 2'd0, 0, 0));
        obs_q.push_back(sample());
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(ev(1, 16'h44, 2'd0, 3'd1, 2'd1, 0, 0));
        obs_q.push_back(sample());
        bp_ras_push = 1'b0;
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL async_reset step %0d: got %s want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        test_reset();
        test_recursion();
        test_overflow();
        test_restore();
        test_push_pop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
